mips_id_ex_register: RTL



---
 rtl/mips_id_ex_register_pkg.sv | 18 +
 rtl/mips_pipe_reg.sv | 26 ++
 rtl/mips_id_ex_register.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_id_ex_register_pkg.sv
// Shared definitions for the ID/EX pipeline register and the EX/control blocks
// that consume its outputs.
package mips_id_ex_register_pkg;

    localparam int DEF_SIZE     = 32;
    localparam int DEF_REG_ADDR = 5;
    localparam int DEF_ALUOP_W  = 2;
    localparam int SHAMT_W      = 5;
    localparam int NUM_CTRL     = 7;

    // ALU operation class passed from decode to the ALU control block
    typedef enum logic [DEF_ALUOP_W-1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

endpackage

// File: rtl/mips_pipe_reg.sv
// Generic pipeline register: async active-low reset, synchronous clear
// (higher priority) and load enable.
module mips_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: state is written with <= only, so every flop samples pre-edge values
    // and neighbouring pipeline stages never race each other.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mips_id_ex_register.sv
// ID/EX pipeline register: one data bundle and one control bundle, with
// flush > stall > load priority and control killed for non-valid entries.
module mips_id_ex_register
    import mips_id_ex_register_pkg::*;
#(
    parameter int SIZE     = DEF_SIZE,
    parameter int REG_ADDR = DEF_REG_ADDR,
    parameter int ALUOP_W  = DEF_ALUOP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                flush,
    input  logic                id_valid,
    input  logic [SIZE-1:0]     id_pcplus4,
    input  logic [SIZE-1:0]     id_readdata1,
    input  logic [SIZE-1:0]     id_readdata2,
    input  logic [SIZE-1:0]     id_signextimm,
    input  logic [REG_ADDR-1:0] id_rs,
    input  logic [REG_ADDR-1:0] id_rt,
    input  logic [REG_ADDR-1:0] id_rd,
    input  logic [SHAMT_W-1:0]  id_shamt,
    input  logic                id_regwrite,
    input  logic                id_memtoreg,
    input  logic                id_memread,
    input  logic                id_memwrite,
    input  logic                id_alusrc,
    input  logic                id_regdst,
    input  logic                id_branch,
    input  logic [ALUOP_W-1:0]  id_aluop,
    output logic                ex_valid,
    output logic [SIZE-1:0]     ex_pcplus4,
    output logic [SIZE-1:0]     ex_readdata1,
    output logic [SIZE-1:0]     ex_readdata2,
    output logic [SIZE-1:0]     ex_signextimm,
    output logic [REG_ADDR-1:0] ex_rs,
    output logic [REG_ADDR-1:0] ex_rt,
    output logic [REG_ADDR-1:0] ex_rd,
    output logic [SHAMT_W-1:0]  ex_shamt,
    output logic                ex_regwrite,
    output logic                ex_memtoreg,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic                ex_alusrc,
    output logic                ex_regdst,
    output logic                ex_branch,
    output logic [ALUOP_W-1:0]  ex_aluop
);

    localparam int DATA_W = 4 * SIZE + 3 * REG_ADDR + SHAMT_W;
    localparam int CTRL_W = 1 + NUM_CTRL + ALUOP_W;

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic [CTRL_W-1:0] ctrl_raw;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;

    assign data_d = {id_pcplus4, id_readdata1, id_readdata2, id_signextimm,
                     id_rs, id_rt, id_rd, id_shamt};

    assign ctrl_raw = {id_valid, id_regwrite, id_memtoreg, id_memread, id_memwrite,
                       id_alusrc, id_regdst, id_branch, id_aluop};

    // A non-valid instruction carries data through but can never commit anything.
    assign ctrl_d = id_valid ? ctrl_raw : '0;

    mips_pipe_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (!stall),
        .d     (data_d),
        .q     (data_q)
    );

    mips_pipe_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .en    (!stall),
        .d     (ctrl_d),
        .q     (ctrl_q)
    );

    assign {ex_pcplus4, ex_readdata1, ex_readdata2, ex_signextimm,
            ex_rs, ex_rt, ex_rd, ex_shamt} = data_q;

    assign {ex_valid, ex_regwrite, ex_memtoreg, ex_memread, ex_memwrite,
            ex_alusrc, ex_regdst, ex_branch, ex_aluop} = ctrl_q;

endmodule
